// File: rtl/rom_stream_reader_pkg.sv
// Shared definitions for the ROM stream reader: FSM encoding and address-width helper.
package rom_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width that addresses 0..depth-1; depth need not be a power of two.
    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rom_stream_reader_skid_fifo.sv
// Two-entry FIFO with a registered head; head_data/head_valid drive the stream outputs directly.
module rom_stream_reader_skid_fifo #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [width-1:0] tail_data;
    logic             tail_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                head_data  <= tail_data;
                tail_data  <= push_data;
                tail_valid <= push;
            end else begin
                head_data  <= push_data;
                head_valid <= push;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_data  <= push_data;
                head_valid <= 1'b1;
            end else begin
                tail_data  <= push_data;
                tail_valid <= 1'b1;
            end
        end
    end

    assign count = {1'b0, head_valid} + {1'b0, tail_valid};

endmodule

// File: rtl/rom_stream_reader.sv
// Fetches `length` consecutive ROM words from baseAddr and streams them out with valid/ready.
//   state    | meaning
//   ST_IDLE  | waiting for start; baseAddr/length sampled here
//   ST_RUN   | issuing ROM reads while credit allows
//   ST_DRAIN | all reads issued, waiting for the last beat to be accepted
//   ST_DONE  | one-cycle done pulse, then back to idle
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int blockLength = 8,
    parameter int memDepth    = 4096,
    localparam int addressBitWidth = addr_width(memDepth)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [addressBitWidth-1:0] baseAddr,
    input  logic [addressBitWidth:0]   length,
    output logic                       busy,
    output logic                       done,
    output logic [addressBitWidth-1:0] romAddress,
    input  logic [blockLength-1:0]     romData,
    output logic [blockLength-1:0]     outData,
    output logic                       outValid,
    input  logic                       outReady
);

    state_t                     state, state_next;
    logic [addressBitWidth-1:0] addr_cnt, rom_addr_q;
    logic [addressBitWidth:0]   issue_cnt, recv_cnt;
    logic                       in_flight;
    logic [1:0]                 buf_count;
    logic [2:0]                 credit_used;
    logic                       issue, pop;

    assign pop = outValid & outReady;
    // A beat leaving this cycle frees its slot, so steady state sustains one beat per cycle.
    assign credit_used = {2'b0, in_flight} + {1'b0, buf_count} - {2'b0, pop};
    assign issue       = (state == ST_RUN) && (credit_used < 3'd2);
    assign romAddress  = issue ? addr_cnt : rom_addr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (length != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (issue && issue_cnt == (addressBitWidth+1)'(1)) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && recv_cnt == (addressBitWidth+1)'(1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_cnt   <= '0;
            rom_addr_q <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            in_flight  <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                rom_addr_q <= addr_cnt;
                addr_cnt   <= (addr_cnt == addressBitWidth'(memDepth-1)) ? '0 : addr_cnt + 1'b1;
                issue_cnt  <= issue_cnt - 1'b1;
            end
            if (state == ST_IDLE && start) begin
                addr_cnt  <= baseAddr;
                issue_cnt <= length;
                recv_cnt  <= length;
            end else if (pop) begin
                recv_cnt <= recv_cnt - 1'b1;
            end
        end
    end

    rom_stream_reader_skid_fifo #(
        .width (blockLength)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (in_flight),
        .push_data  (romData),
        .pop        (pop),
        .head_data  (outData),
        .head_valid (outValid),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench: 16-word ROM model (word[i] = i + 8'h10) behind rom_stream_reader.
module tb_rom_stream_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] baseAddr;
    logic [4:0] length;
    logic       busy, done;
    logic [3:0] romAddress;
    logic [7:0] romData;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;

    logic [7:0] rom [16];
    int         n_checks = 0;
    int         n_errors = 0;
    int         held_addr;

    always #5 clock = ~clock;

    initial for (int i = 0; i < 16; i++) rom[i] = 8'(i + 16);
    always @(posedge clock) romData <= rom[romAddress];

    rom_stream_reader #(
        .blockLength (8),
        .memDepth    (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .baseAddr   (baseAddr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .romAddress (romAddress),
        .romData    (romData),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high, 1: ready on odd cycles, 2: fixed irregular pattern
    task automatic do_xfer(input string tag, input int base, input int len, input int mode,
                           input bit poke);
        logic [7:0]  beat_dat[$];
        int          beat_cyc[$];
        logic [3:0]  addr_seq[$];
        logic [3:0]  prev_addr;
        logic [7:0]  prev_data;
        logic [31:0] pat;
        logic        prev_stall, rdy;
        int done_cyc, done_cnt, busy_cnt, viol_stable, viol_buf, viol_gap, viol_addr, skip, exp_done;
        int seen[16];
        pat = 32'hB3A5_9C4E;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        viol_stable = 0; viol_buf = 0; viol_gap = 0; viol_addr = 0;
        prev_stall = 1'b0; prev_data = '0; rdy = 1'b0;
        for (int i = 0; i < 16; i++) seen[i] = 0;
        prev_addr = 4'(held_addr);

        @(negedge clock);
        start = 1'b1; baseAddr = 4'(base); length = 5'(len); outReady = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clock);
            start = poke && (c == 2);
            if (poke && c == 2) begin
                baseAddr = 4'd0;
                length   = 5'd1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = c[0];
                default: rdy = pat[c % 32];
            endcase
            outReady = rdy;
            #1;
            if (prev_stall && (!outValid || outData !== prev_data)) viol_stable++;
            if (dut.buf_count > 2'd2) viol_buf++;
            if (romAddress !== prev_addr) begin
                addr_seq.push_back(romAddress);
                prev_addr = romAddress;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (outValid && rdy) begin
                beat_dat.push_back(outData);
                beat_cyc.push_back(c);
            end
            prev_stall = outValid && !rdy;
            prev_data  = outData;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0; outReady = 1'b0;

        check_eq({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check_eq({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, " beat_count"}, 32'(beat_dat.size()), 32'(len));
        for (int i = 0; i < beat_dat.size() && i < len; i++) begin
            check_eq($sformatf("%s beat%0d", tag, i), 32'(beat_dat[i]), 32'(((base + i) % 16) + 16));
            seen[beat_dat[i][3:0]]++;
        end
        if (len == 0) exp_done = 1;
        else          exp_done = (beat_cyc.size() > 0) ? beat_cyc[$] + 1 : -2;
        check_eq({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
        check_eq({tag, " held_stable"}, 32'(viol_stable), 32'd0);
        check_eq({tag, " buf_bound"}, 32'(viol_buf), 32'd0);

        skip = (len > 0 && (base % 16) == held_addr) ? 1 : 0;
        check_eq({tag, " addr_changes"}, 32'(addr_seq.size()), 32'(len - skip));
        for (int i = 0; i < addr_seq.size(); i++)
            if (int'(addr_seq[i]) != (base + skip + i) % 16) viol_addr++;
        check_eq({tag, " addr_order"}, 32'(viol_addr), 32'd0);

        if (mode == 0 && len > 0) begin
            check_eq({tag, " first_beat_cycle"}, 32'(beat_cyc.size() > 0 ? beat_cyc[0] : -1), 32'd3);
            for (int i = 0; i < beat_cyc.size(); i++)
                if (beat_cyc[i] != 3 + i) viol_gap++;
            check_eq({tag, " back_to_back"}, 32'(viol_gap), 32'd0);
        end
        if (len == 16) begin
            viol_addr = 0;
            for (int i = 0; i < 16; i++) if (seen[i] != 1) viol_addr++;
            check_eq({tag, " each_once"}, 32'(viol_addr), 32'd0);
        end
        if (len > 0) held_addr = (base + len - 1) % 16;
    endtask

    task automatic abort_xfer();
        int beats;
        beats = 0;
        @(negedge clock);
        start = 1'b1; baseAddr = 4'd8; length = 5'd8; outReady = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (outValid) begin
                check_eq($sformatf("abort beat%0d", beats), 32'(outData), 32'(8'h18 + beats));
                beats++;
            end
            if (beats == 2) break;
        end
        check_eq("abort reached_beat2", 32'(beats), 32'd2);
        reset_n = 1'b0;
        #1;
        check_eq("abort outValid", 32'(outValid), 32'd0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        check_eq("abort romAddress", 32'(romAddress), 32'd0);
        outReady = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        held_addr = 0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; baseAddr = '0; length = '0; outReady = 1'b0;
        held_addr = 0;
        repeat (3) @(negedge clock);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset outValid", 32'(outValid), 32'd0);
        check_eq("reset outData", 32'(outData), 32'd0);
        check_eq("reset romAddress", 32'(romAddress), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        do_xfer("t1", 3, 5, 0, 1'b1);
        do_xfer("t2", 14, 4, 0, 1'b0);
        do_xfer("t3a", 9, 6, 1, 1'b0);
        do_xfer("t3b", 2, 6, 2, 1'b0);
        do_xfer("t4", 5, 0, 0, 1'b0);
        abort_xfer();
        do_xfer("t5", 0, 2, 0, 1'b0);
        do_xfer("t6", 5, 16, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
